// File: rtl/cmsdk_ahb_flash16_pkg.sv
// Shared definitions for the AHB-Lite to 16-bit flash read bridge:
// FSM state encoding, AHB transfer/response codes and counter sizing.
package cmsdk_ahb_flash16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_ERR1  = 3'd3,
        ST_ERR2  = 3'd4
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Wait-state counter width: enough bits to reach WS, never fewer than one.
    function automatic int cnt_width(input int ws);
        return (ws < 1) ? 1 : $clog2(ws + 1);
    endfunction

endpackage

// File: rtl/cmsdk_ahb_to_flash16_if.sv
// AHB-Lite slave-side bus bundle for the 16-bit flash bridge.
// A transfer is accepted on an HCLK edge where HSEL, HTRANS[1] and HREADY are all high;
// its data phase ends on the first edge where HREADYOUT is high.
interface cmsdk_ahb_to_flash16_if #(
    parameter int AW = 16
);
    logic          HSEL;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/cmsdk_flash16_ws_counter.sv
// Flash wait-state counter: restarts at 0 on every flash address load and
// flags done once the address has been held for WS+1 cycles.
module cmsdk_flash16_ws_counter
    import cmsdk_ahb_flash16_pkg::*;
#(
    parameter int WS = 0
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic load,
    output logic done
);
    localparam int CW = cnt_width(WS);

    logic [CW-1:0] r_count;

    // Saturates at WS so a long IDLE stretch cannot wrap into a false phase end.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (!done) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done = (r_count == CW'(WS));

endmodule

// File: rtl/cmsdk_ahb_to_flash16.sv
// AHB-Lite read bridge onto a 16-bit flash: each word read becomes two halfword fetches,
// each held WS+1 cycles. Define CMSDK_FLASH_WRITE_ERR_EN to answer writes with a two-cycle ERROR.
module cmsdk_ahb_to_flash16
    import cmsdk_ahb_flash16_pkg::*;
#(
    parameter int AW = 16,
    parameter int WS = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    cmsdk_ahb_to_flash16_if.slave   ahb,
    output logic [AW-2:0]           FLASHADDR,
    input  logic [15:0]             FLASHRDATA,
    output state_t                  o_dbg_state
);
    state_t        r_state;
    state_t        w_next;
    logic [AW-2:0] r_flashaddr;
    logic [AW-2:0] w_flashaddr_nxt;
    logic [15:0]   r_low;
    logic          r_word;
    logic          w_word_nxt;
    logic          w_load;
    logic          w_low_en;
    logic          w_done;
    logic          w_ready;
    logic          w_resp;
    logic          w_accept;
    logic          w_complete;
    logic          w_unused;

    assign w_accept = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
    assign w_unused = ^{ahb.HSIZE[2], ahb.HSIZE[0], ahb.HTRANS[0], ahb.HADDR[0]};

    cmsdk_flash16_ws_counter #(.WS(WS)) u_ws_counter (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .load    (w_load),
        .done    (w_done)
    );

    always_comb begin
        w_next          = r_state;
        w_flashaddr_nxt = r_flashaddr;
        w_word_nxt      = r_word;
        w_load          = 1'b0;
        w_low_en        = 1'b0;
        w_ready         = 1'b1;
        w_resp          = HRESP_OKAY;
        case (r_state)
            ST_RD_LO: begin
                w_ready = 1'b0;
                if (w_done) begin
                    w_next          = ST_RD_HI;
                    w_flashaddr_nxt = r_flashaddr + 1'b1;
                    w_load          = 1'b1;
                    w_low_en        = 1'b1;
                end
            end
            ST_RD_HI: w_ready = w_done;
`ifdef CMSDK_FLASH_WRITE_ERR_EN
            ST_ERR1: begin
                w_ready = 1'b0;
                w_resp  = HRESP_ERROR;
                w_next  = ST_ERR2;
            end
            ST_ERR2: w_resp = HRESP_ERROR;
`endif
            default: ;
        endcase
        // Any cycle that ends a data phase may accept the next transfer at the same edge.
        if (w_ready) begin
            w_next = ST_IDLE;
            if (w_accept) begin
                if (ahb.HWRITE) begin
`ifdef CMSDK_FLASH_WRITE_ERR_EN
                    w_next = ST_ERR1;
`endif
                end else if (ahb.HSIZE[1]) begin
                    w_next          = ST_RD_LO;
                    w_flashaddr_nxt = {ahb.HADDR[AW-1:2], 1'b0};
                    w_word_nxt      = 1'b1;
                    w_load          = 1'b1;
                end else begin
                    w_next          = ST_RD_HI;
                    w_flashaddr_nxt = ahb.HADDR[AW-1:1];
                    w_word_nxt      = 1'b0;
                    w_load          = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_flashaddr <= '1;
            r_low       <= '0;
            r_word      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_flashaddr <= w_flashaddr_nxt;
            r_word      <= w_word_nxt;
            if (w_low_en) begin
                r_low <= FLASHRDATA;
            end
        end
    end

    // Upper lane always comes straight from the flash; the lower lane is either the
    // registered first halfword (word read) or the same halfword replicated.
    assign w_complete    = (r_state == ST_RD_HI) && w_done;
    assign ahb.HRDATA    = w_complete ? {FLASHRDATA, (r_word ? r_low : FLASHRDATA)} : 32'h0;
    assign ahb.HREADYOUT = w_ready;
    assign ahb.HRESP     = w_resp;
    assign FLASHADDR     = r_flashaddr;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cmsdk_ahb_to_flash16.sv
// Bench for cmsdk_ahb_to_flash16: four bridges with WS=0..3, each on its own flash model
// holding byte i = i[7:0]; directed scenarios plus randomized read/write sequences.
module tb_cmsdk_ahb_to_flash16;
    import cmsdk_ahb_flash16_pkg::*;

`ifdef CMSDK_FLASH_WRITE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int NDUT = 4;
    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel[NDUT];
    logic [15:0] haddr[NDUT];
    logic [1:0]  htrans[NDUT];
    logic [2:0]  hsize[NDUT];
    logic        hwrite[NDUT];
    logic        hreadyout[NDUT];
    logic        hresp[NDUT];
    logic [31:0] hrdata[NDUT];
    logic [14:0] faddr[NDUT];
    logic [15:0] frdata[NDUT];
    state_t      dbg[NDUT];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [15:0] req_a[$];
    logic [2:0]  req_sz[$];
    logic        req_wr[$];
    logic [31:0] res_data[$];
    int          res_waits[$];
    logic        res_rf[$];
    logic        res_rl[$];
    logic [14:0] trace[$];
    logic [14:0] model_fa[NDUT];

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < NDUT; g++) begin : gen_dut
        cmsdk_ahb_to_flash16_if #(.AW(16)) bus ();
        logic [14:0] last_a;
        int          stab;

        assign bus.HSEL    = hsel[g];
        assign bus.HADDR   = haddr[g];
        assign bus.HTRANS  = htrans[g];
        assign bus.HSIZE   = hsize[g];
        assign bus.HWRITE  = hwrite[g];
        assign bus.HREADY  = bus.HREADYOUT;
        assign hreadyout[g] = bus.HREADYOUT;
        assign hresp[g]     = bus.HRESP;
        assign hrdata[g]    = bus.HRDATA;

        cmsdk_ahb_to_flash16 #(.AW(16), .WS(g)) dut (
            .HCLK        (clk),
            .HRESETn     (rst_n),
            .ahb         (bus.slave),
            .FLASHADDR   (faddr[g]),
            .FLASHRDATA  (frdata[g]),
            .o_dbg_state (dbg[g])
        );

        // Flash model: data is garbage until the address has been stable WS cycles.
        initial begin
            last_a = 'x;
            stab   = 0;
        end
        always @(posedge clk) begin
            #1;
            if (faddr[g] !== last_a) begin
                last_a = faddr[g];
                stab   = 0;
            end else begin
                stab = stab + 1;
            end
        end
        assign frdata[g] = (stab >= g) ? {faddr[g][6:0], 1'b1, faddr[g][6:0], 1'b0} : 16'hDEAD;
    end

    function automatic logic [7:0] img_byte(input int unsigned i);
        return i[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle(input int k);
        hsel[k]   = 1'b0;
        htrans[k] = HTRANS_IDLE;
        haddr[k]  = 16'h0;
        hsize[k]  = SZ_BYTE;
        hwrite[k] = 1'b0;
    endtask

    task automatic drive_req(input int k, input logic [15:0] a, input logic [2:0] sz, input logic wr);
        hsel[k]   = 1'b1;
        htrans[k] = HTRANS_NONSEQ;
        haddr[k]  = a;
        hsize[k]  = sz;
        hwrite[k] = wr;
    endtask

    task automatic clear_req();
        req_a.delete();
        req_sz.delete();
        req_wr.delete();
    endtask

    task automatic add_req(input logic [15:0] a, input logic [2:0] sz, input logic wr);
        req_a.push_back(a);
        req_sz.push_back(sz);
        req_wr.push_back(wr);
    endtask

    // Issues the queued requests back-to-back (next address driven during each data phase).
    task automatic run_burst(input int k);
        int n;
        int w;
        n = req_a.size();
        res_data.delete();
        res_waits.delete();
        res_rf.delete();
        res_rl.delete();
        trace.delete();
        @(posedge clk); #1;
        drive_req(k, req_a[0], req_sz[0], req_wr[0]);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i + 1 < n) drive_req(k, req_a[i+1], req_sz[i+1], req_wr[i+1]);
            else drive_idle(k);
            w = 0;
            @(negedge clk);
            res_rf.push_back(hresp[k]);
            trace.push_back(faddr[k]);
            while (hreadyout[k] !== 1'b1 && w < 40) begin
                w++;
                @(negedge clk);
                trace.push_back(faddr[k]);
            end
            check($sformatf("dut%0d_xfer%0d_no_timeout", k, i), 32'(w < 40), 32'd1);
            res_waits.push_back(w);
            res_data.push_back(hrdata[k]);
            res_rl.push_back(hresp[k]);
        end
    endtask

    // Reference: expected data from the byte image, waits and address trace from the fetch rules.
    task automatic check_xfer(input int k, input string tag);
        logic [14:0] fa;
        logic [14:0] exp_tr[$];
        logic [31:0] ed;
        int          ew;
        logic        er;
        int unsigned base;
        int          nt;
        fa = model_fa[k];
        for (int i = 0; i < req_a.size(); i++) begin
            if (req_wr[i]) begin
                ed = 32'h0;
                ew = ERR_EN ? 1 : 0;
                er = ERR_EN;
                for (int j = 0; j <= ew; j++) exp_tr.push_back(fa);
            end else if (req_sz[i][1]) begin
                base = int'(req_a[i]) & 32'hFFFC;
                ed = {img_byte(base + 3), img_byte(base + 2), img_byte(base + 1), img_byte(base)};
                ew = 2 * k + 1;
                er = 1'b0;
                fa = 15'(base / 2);
                for (int j = 0; j <= k; j++) exp_tr.push_back(fa);
                fa = fa + 15'd1;
                for (int j = 0; j <= k; j++) exp_tr.push_back(fa);
            end else begin
                base = int'(req_a[i]) & 32'hFFFE;
                ed = {img_byte(base + 1), img_byte(base), img_byte(base + 1), img_byte(base)};
                ew = k;
                er = 1'b0;
                fa = 15'(base / 2);
                for (int j = 0; j <= k; j++) exp_tr.push_back(fa);
            end
            check($sformatf("%s_%0d_hrdata", tag, i), res_data[i], ed);
            check($sformatf("%s_%0d_waits", tag, i), 32'(res_waits[i]), 32'(ew));
            check($sformatf("%s_%0d_hresp_first", tag, i), 32'(res_rf[i]), 32'(er));
            check($sformatf("%s_%0d_hresp_last", tag, i), 32'(res_rl[i]), 32'(er));
        end
        check($sformatf("%s_trace_len", tag), 32'(trace.size()), 32'(exp_tr.size()));
        nt = (trace.size() < exp_tr.size()) ? trace.size() : exp_tr.size();
        for (int j = 0; j < nt; j++)
            check($sformatf("%s_flashaddr_c%0d", tag, j), 32'(trace[j]), 32'(exp_tr[j]));
        model_fa[k] = fa;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            drive_idle(k);
            model_fa[k] = 15'h7FFF;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_dut%0d_hreadyout", k), 32'(hreadyout[k]), 32'd1);
            check($sformatf("rst_dut%0d_hresp", k), 32'(hresp[k]), 32'd0);
            check($sformatf("rst_dut%0d_hrdata", k), hrdata[k], 32'h0);
            check($sformatf("rst_dut%0d_flashaddr", k), 32'(faddr[k]), 32'h7FFF);
            check($sformatf("rst_dut%0d_state", k), 32'(dbg[k]), 32'(ST_IDLE));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        clear_req(); add_req(16'h0004, SZ_WORD, 1'b0);
        run_burst(2); check_xfer(2, "ws2_word");
        check("ws2_word_const", res_data[0], 32'h07060504);

        clear_req(); add_req(16'h0006, SZ_HALF, 1'b0);
        run_burst(2); check_xfer(2, "ws2_half");
        check("ws2_half_const", res_data[0], 32'h07060706);

        clear_req(); add_req(16'h0010, SZ_WORD, 1'b0);
        run_burst(0); check_xfer(0, "ws0_word");
        check("ws0_word_const", res_data[0], 32'h13121110);

        clear_req(); add_req(16'h0000, SZ_WORD, 1'b0); add_req(16'h0004, SZ_WORD, 1'b0);
        run_burst(1); check_xfer(1, "ws1_b2b");
        check("ws1_b2b_const0", res_data[0], 32'h03020100);
        check("ws1_b2b_const1", res_data[1], 32'h07060504);

        clear_req(); add_req(16'h0000, SZ_WORD, 1'b1);
        run_burst(2); check_xfer(2, "ws2_write");

        clear_req(); add_req(16'h0006, SZ_HALF, 1'b0); add_req(16'h0006, SZ_HALF, 1'b0);
        run_burst(2); check_xfer(2, "ws2_same_addr");

        clear_req(); add_req(16'h0003, SZ_BYTE, 1'b0);
        run_burst(1); check_xfer(1, "ws1_byte");
        check("ws1_byte_const", res_data[0], 32'h03020302);

        @(posedge clk); #1;
        hsel[2] = 1'b1; htrans[2] = HTRANS_BUSY; haddr[2] = 16'h0020; hsize[2] = SZ_WORD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d_hreadyout", c), 32'(hreadyout[2]), 32'd1);
            check($sformatf("busy_c%0d_flashaddr", c), 32'(faddr[2]), 32'(model_fa[2]));
            check($sformatf("busy_c%0d_state", c), 32'(dbg[2]), 32'(ST_IDLE));
        end
        @(posedge clk); #1;
        hsel[2] = 1'b0; htrans[2] = HTRANS_NONSEQ;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("unsel_c%0d_hreadyout", c), 32'(hreadyout[2]), 32'd1);
            check($sformatf("unsel_c%0d_hresp", c), 32'(hresp[2]), 32'd0);
            check($sformatf("unsel_c%0d_flashaddr", c), 32'(faddr[2]), 32'(model_fa[2]));
        end
        @(posedge clk); #1;
        drive_idle(2);

        @(posedge clk); #1;
        drive_req(3, 16'h0020, SZ_WORD, 1'b0);
        @(posedge clk); #1;
        drive_idle(3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_hreadyout", 32'(hreadyout[3]), 32'd1);
        check("midrst_hresp", 32'(hresp[3]), 32'd0);
        check("midrst_flashaddr", 32'(faddr[3]), 32'h7FFF);
        check("midrst_hrdata", hrdata[3], 32'h0);
        check("midrst_state", 32'(dbg[3]), 32'(ST_IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < NDUT; k++) model_fa[k] = 15'h7FFF;
        clear_req(); add_req(16'h0008, SZ_WORD, 1'b0);
        run_burst(3); check_xfer(3, "ws3_after_rst");
        check("ws3_after_rst_const", res_data[0], 32'h0B0A0908);

        for (int k = 0; k < NDUT; k++) begin
            for (int it = 0; it < 8; it++) begin
                clear_req();
                for (int r = 0; r < int'($urandom_range(1, 2)); r++)
                    add_req(16'($urandom_range(0, 65535)), 3'($urandom_range(0, 2)),
                            ($urandom_range(0, 4) == 0));
                run_burst(k);
                check_xfer(k, $sformatf("rnd_dut%0d_it%0d", k, it));
            end
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
